// File: rtl/ahb_burst_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb_burst_seq_if
// Description : Bundle of the host request/write-data handshakes, the
//               master_ahb top-side outputs, the bus observation inputs and
//               the status outputs of ahb_burst_seq.
//               slave  modport : sequencer view (ahb_burst_seq)
//               master modport : environment view (host + master_ahb + bus)
// Revision    : 1.0 - initial release
// ============================================================================
interface ahb_burst_seq_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    // host request channel
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_write;
    logic [3:0]        req_len;
    logic              req_wrap;
    // host write-data channel
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] wdata;
    // master_ahb top-side inputs
    logic [ADDR_W-1:0] addr_top;
    logic [DATA_W-1:0] data_top;
    logic              write_top;
    logic [3:0]        beat_length;
    logic              wrap_enb;
    logic              enb;
    // master_ahb / bus observation
    logic              fifo_full;
    logic              fifo_empty;
    logic              HREADY;
    logic [1:0]        HTRANS;
    // status
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  req_valid, req_addr, req_write, req_len, req_wrap,
        input  wdata_valid, wdata,
        input  fifo_full, fifo_empty, HREADY, HTRANS,
        output req_ready, wdata_ready,
        output addr_top, data_top, write_top, beat_length, wrap_enb, enb,
        output busy, done, err
    );

    modport master (
        output req_valid, req_addr, req_write, req_len, req_wrap,
        output wdata_valid, wdata,
        output fifo_full, fifo_empty, HREADY, HTRANS,
        input  req_ready, wdata_ready,
        input  addr_top, data_top, write_top, beat_length, wrap_enb, enb,
        input  busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/ahb_burst_seq.sv
`default_nettype none
// ============================================================================
// Module      : ahb_burst_seq
// Description : Request sequencer upstream of master_ahb. Accepts a burst
//               request, stages write beats, replays them on data_top at
//               one beat per non-full cycle, arms the master with a 2-cycle
//               enb pulse, then waits for len qualified bus beats.
// Ports       : HCLK    - clock, rising edge
//               HRESETn - asynchronous active-low reset
//               bus     - ahb_burst_seq_if.slave (host handshakes, master
//                         top-side outputs, fifo/bus observation, status)
// Options     : SEQ_TIMEOUT_EN - 8-bit WAIT watchdog; 256 WAIT cycles
//               without completion give an err pulse and return to IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_burst_seq #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 16
) (
    input  wire logic        HCLK,
    input  wire logic        HRESETn,
    ahb_burst_seq_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_ARM     = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]        r_state, w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [3:0]        r_len;
    logic              r_wrap;
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic              r_arm_cnt;
    logic [3:0]        r_beat_cnt;
    logic              r_err;
    logic [DATA_W-1:0] r_buf [DEPTH];

    logic w_accept, w_legal, w_qual, w_wr_last, w_rd_last, w_beats_done, w_timeout;

    assign w_accept  = (r_state == S_IDLE) && bus.req_valid;
    // zero length is never legal; wrapping bursts exist only as 4 or 8 beats
    assign w_legal   = (bus.req_len != 4'd0) &&
                       (!bus.req_wrap || bus.req_len == 4'd4 || bus.req_len == 4'd8);
    // NONSEQ or SEQ with the bus ready
    assign w_qual    = bus.HREADY && (bus.HTRANS == 2'b10 || bus.HTRANS == 2'b11);
    assign w_wr_last = (r_wr_ptr == PTR_W'(r_len - 4'd1));
    assign w_rd_last = (r_rd_ptr == PTR_W'(r_len - 4'd1));
    // writes also need the master's data fifo drained before completing
    assign w_beats_done = (r_beat_cnt == r_len) && (!r_write || bus.fifo_empty);

`ifdef SEQ_TIMEOUT_EN
    logic [7:0] r_wdog;
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            r_wdog <= 8'd0;
        else if (r_state == S_WAIT)
            r_wdog <= r_wdog + 8'd1;
        else
            r_wdog <= 8'd0;
    end
    assign w_timeout = (r_state == S_WAIT) && (r_wdog == 8'hFF);
`else
    assign w_timeout = 1'b0;
`endif

    // state register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    // next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_legal)
                    w_next_state = bus.req_write ? S_COLLECT : S_ARM;
            end
            S_COLLECT: begin
                if (bus.wdata_valid && w_wr_last)
                    w_next_state = S_LOAD;
            end
            S_LOAD: begin
                if (!bus.fifo_full && w_rd_last)
                    w_next_state = S_ARM;
            end
            S_ARM: begin
                if (r_arm_cnt)
                    w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (w_beats_done)
                    w_next_state = S_DONE;
                else if (w_timeout)
                    w_next_state = S_IDLE;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // request latch, pointers and counters
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_len      <= 4'd0;
            r_wrap     <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_arm_cnt  <= 1'b0;
            r_beat_cnt <= 4'd0;
            r_err      <= 1'b0;
        end else begin
            // illegal requests leave the master-facing latch untouched
            if (w_accept && w_legal) begin
                r_addr     <= bus.req_addr;
                r_write    <= bus.req_write;
                r_len      <= bus.req_len;
                r_wrap     <= bus.req_wrap;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_beat_cnt <= 4'd0;
            end
            if (r_state == S_COLLECT && bus.wdata_valid)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            // the pointer holds on the last beat so data_top stays valid
            if (r_state == S_LOAD && !bus.fifo_full && !w_rd_last)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_arm_cnt <= (r_state == S_ARM) ? ~r_arm_cnt : 1'b0;
            // saturate at len so extra qualified beats cannot wrap the count
            if (r_state == S_WAIT && w_qual && r_beat_cnt != r_len)
                r_beat_cnt <= r_beat_cnt + 4'd1;
            r_err <= (w_accept && !w_legal) ||
                     (r_state == S_WAIT && w_timeout && !w_beats_done);
        end
    end

    // staging buffer; contents are only meaningful behind the pointers
    always_ff @(posedge HCLK) begin
        if (r_state == S_COLLECT && bus.wdata_valid)
            r_buf[r_wr_ptr] <= bus.wdata;
    end

    // outputs decode the state directly so enb drops with the async reset
    always_comb begin
        bus.req_ready   = (r_state == S_IDLE);
        bus.wdata_ready = (r_state == S_COLLECT);
        bus.data_top    = (r_state == S_LOAD) ? r_buf[r_rd_ptr] : '0;
        bus.enb         = (r_state == S_ARM);
        bus.busy        = (r_state != S_IDLE);
        bus.done        = (r_state == S_DONE);
        bus.err         = r_err;
        bus.addr_top    = r_addr;
        bus.write_top   = r_write;
        bus.beat_length = r_len;
        bus.wrap_enb    = r_wrap;
    end
endmodule
`default_nettype wire

// File: tb/tb_ahb_burst_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_burst_seq
// Description : Self-checking bench for ahb_burst_seq. A table of burst
//               requests is replayed with cycle-accurate expectations; write
//               beats go into a scoreboard queue when driven and are popped
//               as data_top presents them. Hand-written sequences cover
//               reset mid-burst, async enb drop and the WAIT watchdog
//               (SEQ_TIMEOUT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_burst_seq;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    ahb_burst_seq_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    ahb_burst_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(16)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  len;
        logic        wrap;
        logic        exp_err;
        int          stall_beat;
        int          stall_cyc;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [31:0] exp_q [$];
    logic [31:0] tv0 [4];

    logic [31:0] last_addr;
    logic        last_write;
    logic [3:0]  last_len;
    logic        last_wrap;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge HCLK);
        cyc++;
    endtask

    task automatic idle_inputs();
        bus.req_valid   = 1'b0;
        bus.req_addr    = '0;
        bus.req_write   = 1'b0;
        bus.req_len     = 4'd0;
        bus.req_wrap    = 1'b0;
        bus.wdata_valid = 1'b0;
        bus.wdata       = '0;
        bus.fifo_full   = 1'b0;
        bus.fifo_empty  = 1'b0;
        bus.HREADY      = 1'b0;
        bus.HTRANS      = 2'b00;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},   bus.req_ready,   1);
        check({tag, "_wdata_ready"}, bus.wdata_ready, 0);
        check({tag, "_addr_top"},    bus.addr_top,    0);
        check({tag, "_data_top"},    bus.data_top,    0);
        check({tag, "_write_top"},   bus.write_top,   0);
        check({tag, "_beat_length"}, bus.beat_length, 0);
        check({tag, "_wrap_enb"},    bus.wrap_enb,    0);
        check({tag, "_enb"},         bus.enb,         0);
        check({tag, "_busy"},        bus.busy,        0);
        check({tag, "_done"},        bus.done,        0);
        check({tag, "_err"},         bus.err,         0);
    endtask

    // Entered and left at a negedge with the DUT idle.
    task automatic run_burst(input vec_t v, input int idx);
        int n;
        int stall_left;
        int beat;
        int guard;
        int cnt;
        int j;
        int empty_delay;
        bit fin;
        logic [31:0] d;
        n = int'(v.len);
        check("req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_addr  = v.addr;
        bus.req_write = v.wr;
        bus.req_len   = v.len;
        bus.req_wrap  = v.wrap;
        cyc = 0;
        step();
        bus.req_valid = 1'b0;
        bus.req_addr  = ~v.addr;
        bus.req_len   = 4'd3;
        if (v.exp_err) begin
            check("err_pulse",        bus.err,         1);
            check("err_busy",         bus.busy,        0);
            check("err_req_ready",    bus.req_ready,   1);
            check("err_enb",          bus.enb,         0);
            check("err_addr_kept",    bus.addr_top,    last_addr);
            check("err_len_kept",     bus.beat_length, last_len);
            step();
            check("err_one_cycle",    bus.err,         0);
            check("err_enb_after",    bus.enb,         0);
            return;
        end
        last_addr  = v.addr;
        last_write = v.wr;
        last_len   = v.len;
        last_wrap  = v.wrap;
        check("latched_addr",  bus.addr_top,    v.addr);
        check("latched_write", bus.write_top,   v.wr);
        check("busy_after_acc", bus.busy,       1);
        if (v.wr) begin
            for (int k = 0; k < n; k++) begin
                check("wdata_ready", bus.wdata_ready, 1);
                d = (idx == 0) ? tv0[k] : $urandom;
                bus.wdata       = d;
                bus.wdata_valid = 1'b1;
                exp_q.push_back(d);
                step();
            end
            // left high: the sequencer must ignore it outside COLLECT
            bus.wdata = 32'hDEAD_BEEF;
            stall_left = v.stall_cyc;
            beat  = 0;
            guard = 0;
            while (exp_q.size() > 0 && guard < 64) begin
                check("load_no_wready", bus.wdata_ready, 0);
                check("load_no_enb",    bus.enb,         0);
                check("data_top",       bus.data_top,    exp_q[0]);
                if (beat == v.stall_beat && stall_left > 0) begin
                    bus.fifo_full = 1'b1;
                    stall_left--;
                end else begin
                    bus.fifo_full = 1'b0;
                    void'(exp_q.pop_front());
                    beat++;
                end
                step();
                guard++;
            end
            check("load_drained", exp_q.size(), 0);
            bus.fifo_full   = 1'b0;
            bus.wdata_valid = 1'b0;
        end
        check("arm_cycle", cyc, v.wr ? (2*n + 1 + v.stall_cyc) : 1);
        // qualified bus beats during ARM must not be counted
        bus.HREADY = 1'b1;
        bus.HTRANS = 2'b10;
        for (int a = 0; a < 2; a++) begin
            check("arm_enb",         bus.enb,         1);
            check("arm_beat_length", bus.beat_length, v.len);
            check("arm_wrap_enb",    bus.wrap_enb,    v.wrap);
            check("arm_addr",        bus.addr_top,    v.addr);
            check("arm_data_idle",   bus.data_top,    0);
            step();
        end
        check("enb_two_cycles", bus.enb, 0);
        cnt = 0;
        j = 0;
        empty_delay = 2;
        fin = 1'b0;
        while (!fin && j < 100) begin
            check("no_early_done", bus.done, 0);
            case (j % 4)
                0: begin bus.HREADY = 1'b1; bus.HTRANS = 2'b10; end
                1: begin bus.HREADY = 1'b0; bus.HTRANS = 2'b11; end
                2: begin bus.HREADY = 1'b1; bus.HTRANS = 2'b11; end
                default: begin bus.HREADY = 1'b1; bus.HTRANS = 2'b01; end
            endcase
            bus.fifo_empty = 1'b0;
            if (v.wr && cnt == n) begin
                if (empty_delay > 0) empty_delay--;
                else bus.fifo_empty = 1'b1;
            end
            if (cnt == n && (!v.wr || bus.fifo_empty))
                fin = 1'b1;
            else if (bus.HREADY && bus.HTRANS[1] && cnt < n)
                cnt++;
            step();
            j++;
        end
        check("wait_finished", fin, 1);
        bus.HREADY     = 1'b0;
        bus.HTRANS     = 2'b00;
        bus.fifo_empty = 1'b0;
        check("done_pulse", bus.done, 1);
        check("done_busy",  bus.busy, 1);
        check("done_noerr", bus.err,  0);
        step();
        check("done_one_cycle", bus.done,        0);
        check("idle_after",     bus.req_ready,   1);
        check("hold_addr",      bus.addr_top,    last_addr);
        check("hold_len",       bus.beat_length, last_len);
        check("hold_wrap",      bus.wrap_enb,    last_wrap);
    endtask

    initial begin
        tv0[0] = 32'h0000_0001;
        tv0[1] = 32'h1234_1234;
        tv0[2] = 32'h0000_0002;
        tv0[3] = 32'h0000_0003;
        //          wr    addr          len   wrap  err   stall_beat stall_cyc
        vecs[0] = '{1'b1, 32'h0000_0014, 4'd4,  1'b1, 1'b0, -1, 0};
        vecs[1] = '{1'b0, 32'h0000_0100, 4'd8,  1'b0, 1'b0, -1, 0};
        vecs[2] = '{1'b1, 32'h0000_0200, 4'd5,  1'b1, 1'b1, -1, 0};
        vecs[3] = '{1'b1, 32'h0000_0300, 4'd0,  1'b0, 1'b1, -1, 0};
        vecs[4] = '{1'b0, 32'h0000_0340, 4'd0,  1'b0, 1'b1, -1, 0};
        vecs[5] = '{1'b1, 32'h0000_0400, 4'd4,  1'b0, 1'b0,  2, 3};
        vecs[6] = '{1'b1, 32'h0000_0500, 4'd15, 1'b0, 1'b0, -1, 0};
        vecs[7] = '{1'b1, 32'h0000_0600, 4'd1,  1'b0, 1'b0, -1, 0};
        vecs[8] = '{1'b0, 32'h0000_0700, 4'd8,  1'b1, 1'b0, -1, 0};
        vecs[9] = '{1'b1, 32'h0000_0800, 4'd8,  1'b1, 1'b0,  7, 2};
        last_addr  = '0;
        last_write = 1'b0;
        last_len   = 4'd0;
        last_wrap  = 1'b0;

        idle_inputs();
        repeat (3) @(negedge HCLK);
        check_reset_outputs("in_reset");
        HRESETn = 1'b1;
        step();
        check_reset_outputs("post_reset");

        for (int i = 0; i < NV; i++)
            run_burst(vecs[i], i);

        // reset during COLLECT after 2 of 4 beats
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0900;
        bus.req_write = 1'b1;
        bus.req_len   = 4'd4;
        bus.req_wrap  = 1'b0;
        step();
        bus.req_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.wdata_valid = 1'b1;
            bus.wdata       = 32'hA5A5_0000 + k;
            step();
        end
        check("mid_collect_wready", bus.wdata_ready, 1);
        #2 HRESETn = 1'b0;
        #1 check_reset_outputs("async_rst_collect");
        idle_inputs();
        @(negedge HCLK);
        HRESETn = 1'b1;
        last_addr = '0; last_write = 1'b0; last_len = 4'd0; last_wrap = 1'b0;
        step();
        check_reset_outputs("rst_release");
        run_burst('{1'b1, 32'h0000_0A00, 4'd1, 1'b0, 1'b0, -1, 0}, 99);

        // reset during ARM drops enb without waiting for a clock
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0B00;
        bus.req_write = 1'b0;
        bus.req_len   = 4'd2;
        step();
        bus.req_valid = 1'b0;
        check("arm_before_rst", bus.enb, 1);
        #2 HRESETn = 1'b0;
        #1 check("enb_async_drop", bus.enb, 0);
        check("rst_arm_busy", bus.busy, 0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        last_addr = '0; last_write = 1'b0; last_len = 4'd0; last_wrap = 1'b0;
        step();

        // WAIT with no bus activity
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0C00;
        bus.req_write = 1'b0;
        bus.req_len   = 4'd2;
        cyc = 0;
        step();
        bus.req_valid = 1'b0;
        step();
        step();
        check("wait_entered", bus.enb, 0);
`ifdef SEQ_TIMEOUT_EN
        repeat (255) step();
        check("wdog_still_busy", bus.busy, 1);
        check("wdog_no_err_yet", bus.err,  0);
        step();
        check("wdog_err",     bus.err,       1);
        check("wdog_idle",    bus.busy,      0);
        check("wdog_no_done", bus.done,      0);
        step();
        check("wdog_err_one", bus.err,       0);
        check("wdog_ready",   bus.req_ready, 1);
`else
        repeat (300) step();
        check("no_wdog_busy", bus.busy, 1);
        check("no_wdog_err",  bus.err,  0);
        check("no_wdog_done", bus.done, 0);
        HRESETn = 1'b0;
        step();
        HRESETn = 1'b1;
        step();
        check("no_wdog_cleared", bus.busy, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/ahb_burst_seq.md
# ahb_burst_seq

Request sequencer sitting directly upstream of `master_ahb`. It accepts burst requests and write data from a host-side valid/ready interface and stages a complete write burst internally. It then replays that burst onto the master's top-side inputs (`addr_top`, `data_top`, `write_top`, `beat_length`, `wrap_enb`, `enb`) with the cycle pacing the master expects, and reports completion or error back to the host.

## Interface
- `DATA_W`, 32, data width
- `ADDR_W`, 32, address width
- `DEPTH`, 16, staging buffer entries; must be ≥ 15
- `HCLK`  in  1  system clock, rising edge
- `HRESETn`  in  1  reset; one clock, reset asynchronous and active-low
- `req_valid`  in  1  host request valid
- `req_ready`  out  1  sequencer can accept a request
- `req_addr`  in  ADDR_W  burst start address
- `req_write`  in  1  1 = write, 0 = read
- `req_len`  in  4  beats, 1..15
- `req_wrap`  in  1  wrapping burst
- `wdata_valid`  in  1  write beat valid
- `wdata_ready`  out  1  sequencer accepts write beat
- `wdata`  in  DATA_W  write beat
- `addr_top`  out  ADDR_W  to master
- `data_top`  out  DATA_W  to master, one beat per cycle
- `write_top`  out  1  to master
- `beat_length`  out  4  to master
- `wrap_enb`  out  1  to master
- `enb`  out  1  to master, burst start
- `fifo_full`  in  1  from master; stalls data push
- `fifo_empty`  in  1  from master
- `HREADY`  in  1  bus ready
- `HTRANS`  in  2  bus transfer type
- `busy`  out  1  not IDLE
- `done`  out  1  one-cycle pulse, burst complete
- `err`  out  1  one-cycle pulse, request rejected or timed out

## Operation
- States: IDLE, COLLECT, LOAD, ARM, WAIT, DONE.
- IDLE
  - `req_ready = 1`; handshake is `req_valid && req_ready`.
  - Latch `addr`, `write`, `len`, `wrap`.
- Legality check at acceptance
  - `len == 0` is illegal.
  - `req_wrap` with `len` not 4 or 8 is illegal.
  - Illegal request: `err` pulses the next cycle, state stays IDLE, master outputs are untouched.
- Legal write → COLLECT. Legal read → ARM.
- COLLECT
  - `wdata_ready = 1`; each handshake writes the beat into the staging buffer.
  - After `len` beats → LOAD.
  - `wdata_valid` outside COLLECT is ignored.
- LOAD
  - `data_top` = staged beat *i*; *i* advances by one per cycle while `fifo_full == 0`.
  - `fifo_full == 1` holds `data_top` and *i*.
  - After beat `len-1` is presented with `fifo_full == 0` → ARM.
- ARM
  - `enb = 1` for exactly 2 cycles.
  - `beat_length = len`, `wrap_enb = wrap`, `write_top` and `addr_top` stable.
  - Then → WAIT.
- WAIT
  - Count cycles with `HREADY == 1 && HTRANS[1] == 1`.
  - When the count reaches `len`, and for writes `fifo_empty == 1` → DONE.
- DONE: `done = 1` for one cycle → IDLE.
- `addr_top`, `write_top`, `beat_length`, `wrap_enb` hold their latched values from acceptance until the next acceptance.
- Staging pointers reset at each acceptance.

## Timing
- Reset values:
  - All outputs 0 except `req_ready = 1`.
  - State IDLE; staging pointers and beat counter 0.
- `HRESETn` low mid-operation: immediate return to IDLE, `enb` dropped asynchronously, staged data discarded; no `done`/`err`.
- Write with `len = N`, no stalls, `wdata_valid` held high:
  - Acceptance at cycle 0.
  - COLLECT cycles 1..N.
  - LOAD cycles N+1..2N.
  - `enb` high cycles 2N+1, 2N+2.
- Read, no stalls: `enb` high cycles 1, 2.
- `fifo_full` rising on the final LOAD beat: that beat repeats until `fifo_full` falls; ARM follows the release cycle.
- `req_valid` during a busy state is ignored, not queued.
- Beat counter is 4 bits and saturates at `len`; no wrap-around.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - 8-bit watchdog runs in WAIT.
  - 256 cycles without reaching DONE → `err` pulse, return to IDLE, no `done`.
- Undefined: no watchdog; WAIT waits indefinitely.

## Test plan
- Write, addr 0x14, len 4, wrap, data 0x1, 0x12341234, 0x2, 0x3 → `data_top` shows the four values on consecutive LOAD cycles; `enb` high for 2 cycles with `beat_length = 4`, `wrap_enb = 1`; `done` pulses after 4 qualified HTRANS beats and `fifo_empty`.
- Read, addr 0x100, len 8, incr → no COLLECT/LOAD; `enb` at cycles 1–2; `done` after 8 qualified beats.
- Wrap with len 5, and any request with len 0 → `err` pulse one cycle after acceptance; `enb` never asserted; `req_ready` stays 1.
- Write len 4 with `fifo_full` forced high during LOAD beat 2 for 3 cycles → beat 2 held 3 extra cycles; all 4 beats presented in order; ARM follows.
- `HRESETn` asserted during COLLECT after 2 of 4 beats → all outputs at reset values immediately; a following len-1 write completes normally.
- With `SEQ_TIMEOUT_EN`, HTRANS held IDLE after ARM → `err` pulse 256 cycles into WAIT, then IDLE.
